// File: rtl/async_fifo.sv
// Gray-pointer FIFO on a single clock, structured so that the write and read sides can be split into two domains later.
// Optional build macro ASYNC_FIFO_SYNC_EN: cross-side Gray pointers pass through 2-flop synchronizers.
module async_fifo #(
  parameter int DATA_SIZE = 8,
  parameter int ADDR_SIZE = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_SIZE-1:0] w_data,
  input  logic                 w_en,
  output logic                 w_full,
  input  logic                 r_en,
  output logic [DATA_SIZE-1:0] r_data,
  output logic                 r_empty
);

  localparam int DEPTH = 1 << ADDR_SIZE;
  localparam int PW    = ADDR_SIZE + 1;
  // A full FIFO is one whose write pointer leads the read pointer by exactly DEPTH.
  // In Gray code that means the two top bits differ and all the remaining bits match.
  localparam logic [PW-1:0] GRAY_FULL_MASK = PW'(3) << (PW - 2);

  logic [DATA_SIZE-1:0] r_mem [DEPTH];

  logic [PW-1:0] r_wbin;
  logic [PW-1:0] r_wgray;
  logic [PW-1:0] r_rbin;
  logic [PW-1:0] r_rgray;
  logic          r_full;
  logic          r_empty_q;

  logic          w_wr;
  logic          w_rd;
  logic          w_both;
  logic [PW-1:0] w_wbin_next;
  logic [PW-1:0] w_wgray_next;
  logic [PW-1:0] w_rbin_next;
  logic [PW-1:0] w_rgray_next;
  logic [PW-1:0] w_wgray_seen;
  logic [PW-1:0] w_rgray_seen;
  logic          w_full_next;
  logic          w_empty_next;

  assign w_wr = w_en && !r_full;
  assign w_rd = r_en && !r_empty_q;

  assign w_wbin_next  = r_wbin + PW'(w_wr);
  assign w_wgray_next = (w_wbin_next >> 1) ^ w_wbin_next;
  assign w_rbin_next  = r_rbin + PW'(w_rd);
  assign w_rgray_next = (w_rbin_next >> 1) ^ w_rbin_next;

`ifdef ASYNC_FIFO_SYNC_EN
  logic [PW-1:0] r_wq1;
  logic [PW-1:0] r_wq2;
  logic [PW-1:0] r_rq1;
  logic [PW-1:0] r_rq2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wq1 <= '0;
      r_wq2 <= '0;
      r_rq1 <= '0;
      r_rq2 <= '0;
    end else begin
      r_wq1 <= r_wgray;
      r_wq2 <= r_wq1;
      r_rq1 <= r_rgray;
      r_rq2 <= r_rq1;
    end
  end

  assign w_wgray_seen = r_wq2;
  assign w_rgray_seen = r_rq2;
  // Synchronized views lag anyway, so the flags stay conservative without any cross-side term.
  assign w_both       = 1'b0;
`else
  assign w_wgray_seen = r_wgray;
  assign w_rgray_seen = r_rgray;
  // A read and a write in the same cycle leave the occupancy unchanged. The flag must keep its value,
  // so it must not take the transient match against the opposite pointer's pre-edge value.
  assign w_both       = w_wr && w_rd;
`endif

  assign w_empty_next = (w_rgray_next == w_wgray_seen) && !w_both;
  assign w_full_next  = (w_wgray_next == (w_rgray_seen ^ GRAY_FULL_MASK)) && !w_both;

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wbin[ADDR_SIZE-1:0]] <= w_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wbin  <= '0;
      r_wgray <= '0;
      r_full  <= 1'b0;
    end else begin
      r_wbin  <= w_wbin_next;
      r_wgray <= w_wgray_next;
      r_full  <= w_full_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rbin    <= '0;
      r_rgray   <= '0;
      r_empty_q <= 1'b1;
    end else begin
      r_rbin    <= w_rbin_next;
      r_rgray   <= w_rgray_next;
      r_empty_q <= w_empty_next;
    end
  end

  assign r_data  = r_mem[r_rbin[ADDR_SIZE-1:0]];
  assign w_full  = r_full;
  assign r_empty = r_empty_q;

endmodule

// File: tb/tb_async_fifo.sv
// Directed plus randomized bench for async_fifo against a queue/occupancy reference model.
module tb_async_fifo;
  localparam int DEPTH = 16;
`ifdef ASYNC_FIFO_SYNC_EN
  localparam int SD = 2;
`else
  localparam int SD = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       w_en;
  logic       r_en;
  logic [7:0] w_data;
  logic       w_full;
  logic       r_empty;
  logic [7:0] r_data;

  async_fifo #(.DATA_SIZE(8), .ADDR_SIZE(4)) dut (
    .clk(clk), .rst(rst), .w_data(w_data), .w_en(w_en), .w_full(w_full),
    .r_en(r_en), .r_data(r_data), .r_empty(r_empty)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference: stored words, total accepted writes/reads, and totals as they were 0..2 edges ago
  logic [7:0] q[$];
  int wtot, rtot;
  int whist[3];
  int rhist[3];
  bit m_empty, m_full;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic we, input logic [7:0] wd, input logic re, input logic rs);
    bit wr, rd;
    int sw, sr;
    w_en = we; w_data = wd; r_en = re; rst = rs;
    @(posedge clk);
    if (rs) begin
      q.delete();
      wtot = 0; rtot = 0;
      whist = '{0, 0, 0};
      rhist = '{0, 0, 0};
      m_empty = 1'b1; m_full = 1'b0;
    end else begin
      wr = we && !m_full;
      rd = re && !m_empty;
      sw = whist[SD];
      sr = rhist[SD];
      if (rd) begin void'(q.pop_front()); rtot++; end
      if (wr) begin q.push_back(wd); wtot++; end
      m_empty = (rtot == sw) && !(SD == 0 && rd && wr);
      m_full  = (wtot - sr == DEPTH) && !(SD == 0 && rd && wr);
      whist[2] = whist[1]; whist[1] = whist[0]; whist[0] = wtot;
      rhist[2] = rhist[1]; rhist[1] = rhist[0]; rhist[0] = rtot;
    end
    #1;
    chk("r_empty", 32'(r_empty), 32'(m_empty));
    chk("w_full", 32'(w_full), 32'(m_full));
    if (q.size() > 0) chk("r_data", 32'(r_data), 32'(q[0]));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    w_en = 1'b0; r_en = 1'b0; w_data = '0; rst = 1'b1;

    // reset
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("reset_empty", 32'(r_empty), 32'd1);
    chk("reset_full", 32'(w_full), 32'd0);
    idle(2);

    // four writes then six reads, the last two while empty
    for (int i = 0; i < 4; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    idle(SD);
    for (int i = 0; i < 6; i++) begin
      if (i < 4) chk("seq4_data", 32'(r_data), 32'(i));
      step(1'b0, 8'h00, 1'b1, 1'b0);
      if (i == 3) chk("seq4_empty", 32'(r_empty), 32'd1);
      chk("seq4_nofull", 32'(w_full), 32'd0);
    end

    // overfill by two, then drain with extra reads
    for (int i = 0; i < 18; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
      if (i == 15) chk("fill_full", 32'(w_full), 32'd1);
    end
    idle(SD);
    for (int i = 0; i < 18; i++) begin
      if (i < 16) chk("fill_data", 32'(r_data), 32'(i));
      step(1'b0, 8'h00, 1'b1, 1'b0);
      if (i == 15) chk("drain_empty", 32'(r_empty), 32'd1);
    end

    // empty deassert latency
    idle(3);
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    n = 0;
    while (r_empty === 1'b1 && n < 10) begin idle(1); n++; end
    chk("empty_latency", 32'(n), 32'(SD + 1));
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // full deassert latency
    idle(3);
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    idle(3);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    n = 0;
    while (w_full === 1'b1 && n < 10) begin idle(1); n++; end
    chk("full_latency", 32'(n), 32'(SD + 1));
    for (int i = 0; i < 15; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    idle(3);
    chk("lat_drained", 32'(r_empty), 32'd1);

    // level held at 5 across pointer wraps
    for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    idle(3);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 8'($urandom), 1'b1, 1'b0);
      chk("wrap_noempty", 32'(r_empty), 32'd0);
      chk("wrap_nofull", 32'(w_full), 32'd0);
    end
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    idle(3);

    // simultaneous read/write while full: read taken, write dropped
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    idle(3);
    step(1'b1, 8'hEE, 1'b1, 1'b0);
    chk("full_rw_data", 32'(r_data), 32'h81);
    idle(3);
    for (int i = 0; i < 14; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("full_rw_last", 32'(r_data), 32'h8F);
    idle(3);
`ifndef ASYNC_FIFO_SYNC_EN
    // simultaneous read/write holding one word
    step(1'b1, 8'h55, 1'b1, 1'b0);
    chk("one_rw_empty", 32'(r_empty), 32'd0);
    chk("one_rw_data", 32'(r_data), 32'h55);
`endif
    while (q.size() > 0) step(1'b0, 8'h00, 1'b1, 1'b0);
    idle(3);

    // randomized traffic
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 99) < 55), 8'($urandom), 1'($urandom_range(0, 99) < 45), 1'b0);
    while (q.size() > 0) step(1'b0, 8'h00, 1'b1, 1'b0);
    idle(3);

    // reset with seven words stored
    for (int i = 0; i < 7; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("midrst_empty", 32'(r_empty), 32'd1);
    chk("midrst_full", 32'(w_full), 32'd0);
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    chk("midrst_data", 32'(r_data), 32'hA5);
    idle(4);
    chk("midrst_avail", 32'(r_empty), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
